sigmoid_lut_arbiter: RTL and testbench

//   Shares one registered sigmoid lookup ROM between N_REQ neuron activation units.

---
 rtl/sigmoid_lut_arbiter.sv | 124 ++++++++++++
 tb/tb_sigmoid_lut_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_lut_arbiter
// Purpose  : Shares one registered sigmoid lookup ROM between N_REQ neuron
//            activation units. Round-robin arbitration with valid/ready
//            handshakes, at most one lookup issued per cycle. Each result
//            comes back on a shared response bus, tagged with the ID of the
//            requester that issued it.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            enable                - 0 stops new grants (in-flight lookups finish)
//            req_valid/req_addr    - per-requester request and packed address
//            req_ready             - one-hot grant
//            rom_addr / rom_data   - registered ROM address, ROM read data
//            rsp_valid/rsp_id/rsp_data - tagged single-cycle response
//            busy                  - any lookup in flight
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid_lut_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ROM_LAT    = 1,
    parameter int ID_WIDTH   = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_data,
    output logic                        rsp_valid,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        busy
);

    // Pointer resets to the last requester so requester 0 wins first.
    localparam logic [ID_WIDTH-1:0] C_PTR_RST = ID_WIDTH'(N_REQ - 1);

    logic [ID_WIDTH-1:0]              r_ptr;
    logic [N_REQ-1:0]                 w_grant;
    logic [ID_WIDTH-1:0]              w_grant_id;
    logic [ID_WIDTH-1:0]              w_idx;
    logic                             w_found;
    logic                             w_hs;
    logic [ADDR_WIDTH-1:0]            w_addr [N_REQ];

    // Tag pipeline: stage 0 is loaded on the grant edge, stage ROM_LAT
    // lines up with the cycle in which rom_data holds the matching result.
    logic [ROM_LAT:0]                 r_tag_v;
    logic [ROM_LAT:0][ID_WIDTH-1:0]   r_tag_id;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_addr_unpack
            assign w_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_idx      = '0;
        w_found    = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_idx = ID_WIDTH'((int'(r_ptr) + off) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_grant_id     = w_idx;
            end
        end
        // Reset is asynchronous, so ready must be masked combinationally too.
        if (!enable || !rst_n) begin
            w_grant    = '0;
            w_grant_id = '0;
        end
    end

    // req_ready is only ever set on a valid requester, so any grant is a handshake.
    assign req_ready = w_grant;
    assign w_hs      = |w_grant;
    assign busy      = |r_tag_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            r_ptr    <= C_PTR_RST;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0] <= w_hs;
            if (w_hs) begin
                rom_addr    <= w_addr[w_grant_id];
                r_ptr       <= w_grant_id;
                r_tag_id[0] <= w_grant_id;
            end
            for (int s = 1; s <= ROM_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    // Response capture; id/data hold their last value between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= r_tag_v[ROM_LAT];
            if (r_tag_v[ROM_LAT]) begin
                rsp_id   <= r_tag_id[ROM_LAT];
                rsp_data <= rom_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_lut_arbiter
// Purpose  : Self-checking bench for sigmoid_lut_arbiter with a registered
//            ROM model, a queue-based reference model, a vector table and
//            directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_lut_arbiter;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int LAT = 1;
    localparam int IW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    always #5 clk = ~clk;

    sigmoid_lut_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(LAT), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = {6'd0, a} * 16'd37;
        return t ^ 16'hA5C3;
    endfunction

    // Registered ROM, one cycle of latency.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [AW-1:0] addr;
    } pend_t;

    pend_t          q[$];
    int             m_ptr;
    int             m_cyc;
    logic [AW-1:0]  m_rom_addr;
    logic [IW-1:0]  m_rsp_id;
    logic [DW-1:0]  m_rsp_data;
    logic [N-1:0]   last_ready;
    logic           last_rsp_valid;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic en);
        if (!en) return -1;
        for (int o = 1; o <= N; o++) begin
            int idx;
            idx = (m_ptr + o) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the
    // grant, advance the model at the rising edge, check outputs at the next fall.
    task automatic step(input logic [N-1:0] v, input logic en, input logic [N*AW-1:0] a);
        int   g;
        logic exp_v;
        req_valid = v;
        enable    = en;
        req_addr  = a;
        #1;
        g = pick(v, en);
        check("req_ready", req_ready, onehot(g));
        last_ready = req_ready;
        @(posedge clk);
        m_cyc++;
        if (g >= 0) begin
            q.push_back('{m_cyc + LAT + 1, g, a[g*AW +: AW]});
            m_ptr      = g;
            m_rom_addr = a[g*AW +: AW];
        end
        exp_v = 1'b0;
        if (q.size() > 0 && q[0].due == m_cyc) begin
            exp_v      = 1'b1;
            m_rsp_id   = IW'(q[0].id);
            m_rsp_data = rom_fn(q[0].addr);
            void'(q.pop_front());
        end
        @(negedge clk);
        last_rsp_valid = rsp_valid;
        check("rsp_valid", rsp_valid, exp_v);
        check("rsp_id",    rsp_id,    m_rsp_id);
        check("rsp_data",  rsp_data,  m_rsp_data);
        check("rom_addr",  rom_addr,  m_rom_addr);
        check("busy",      busy,      q.size() > 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, '0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        enable    = 1'b1;
        #1;
        check("ready_in_reset", req_ready, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",     req_ready, 4'b0000);
        check("rst_rom_addr",  rom_addr,  0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id",    rsp_id,    0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_busy",      busy,      0);
        q.delete();
        m_ptr      = N - 1;
        m_rom_addr = '0;
        m_rsp_id   = '0;
        m_rsp_data = '0;
        req_valid  = '0;
        rst_n      = 1'b1;
    endtask

    function automatic logic [N*AW-1:0] rand_addrs();
        return (N*AW)'({$urandom(), $urandom()});
    endfunction

    typedef struct {
        logic [N-1:0] valid;
        logic         en;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rsp_hist;
        // Grant sequence starting from reset (pointer at requester 3).
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[2]  = '{4'b0011, 1'b1, 4'b0001};
        vecs[3]  = '{4'b0011, 1'b1, 4'b0010};
        vecs[4]  = '{4'b1000, 1'b0, 4'b0000};
        vecs[5]  = '{4'b1000, 1'b1, 4'b1000};
        vecs[6]  = '{4'b0000, 1'b1, 4'b0000};
        vecs[7]  = '{4'b0110, 1'b1, 4'b0010};
        vecs[8]  = '{4'b0110, 1'b1, 4'b0100};
        vecs[9]  = '{4'b1001, 1'b1, 4'b1000};
        vecs[10] = '{4'b1001, 1'b1, 4'b0001};
        vecs[11] = '{4'b0101, 1'b1, 4'b0100};

        m_cyc = 0;
        @(negedge clk);
        do_reset();

        // Idle after reset.
        idle(20);

        // Single request from requester 2 at the top address.
        step(4'b0100, 1'b1, {10'h000, 10'h3FF, 10'h000, 10'h000});
        check("single_ready", last_ready, 4'b0100);
        check("single_rom_addr", rom_addr, 10'h3FF);
        check("single_rsp_early", rsp_valid, 0);
        step('0, 1'b1, '0);
        check("single_rsp_k1", rsp_valid, 0);
        step('0, 1'b1, '0);
        check("single_rsp_k2", rsp_valid, 1);
        check("single_rsp_id", rsp_id, 2);
        check("single_rsp_data", rsp_data, rom_fn(10'h3FF));
        step('0, 1'b1, '0);
        check("single_rsp_drop", rsp_valid, 0);

        // All four requesting continuously.
        do_reset();
        rsp_hist = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                step(4'b1111, 1'b1, rand_addrs());
                check("fair_grant", last_ready, onehot(i % N));
            end else begin
                step('0, 1'b1, '0);
            end
            rsp_hist[i] = last_rsp_valid;
        end
        check("fair_rsp_run", rsp_hist, 10'b1111111100);

        // Table of grant vectors including the wrap case.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].valid, vecs[i].en, rand_addrs());
            check("tbl_ready", last_ready, vecs[i].exp_ready);
        end
        idle(3);

        // enable drops with lookups in flight.
        step(4'b1111, 1'b1, rand_addrs());
        step(4'b1111, 1'b1, rand_addrs());
        check("en_busy_hi", busy, 1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, rand_addrs());
            check("en_off_ready", last_ready, 4'b0000);
        end
        check("en_busy_lo", busy, 0);

        // Reset right after a handshake discards the lookup.
        step(4'b0100, 1'b1, rand_addrs());
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b1, '0);
            check("rst_no_rsp", rsp_valid, 0);
        end
        step(4'b1111, 1'b1, rand_addrs());
        check("rst_grant0", last_ready, 4'b0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0), rand_addrs());
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
